// File: rtl/mem_arb_pkg.sv
// Shared memory-arbiter definitions.
// Default RAM geometry and the arbiter state encoding.
package mem_arb_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick.
// With both requesting, the port that did not win last time wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic gnt
);

  // a lone requester wins; a tie goes to the port other than last
  always_comb begin
    valid = req0 | req1;
    gnt   = 1'b0;
    if (req0 && req1) begin
      gnt = ~last;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single-port data RAM.
// One access per three cycles: sample, RAM access, ack.
module ram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_str,
  output logic          ram_ld,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  arb_state_t    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          str_q, str_d;
  logic          ld_q, ld_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;

  logic          pick_valid;
  logic          pick_gnt;
  logic          sel_we;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .valid (pick_valid),
    .gnt   (pick_gnt)
  );

  assign sel_we = pick_gnt ? we1 : we0;

  // next state and next register values for the arbiter
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    din_d   = din_q;
    str_d   = str_q;
    ld_d    = ld_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          last_d  = pick_gnt;
          addr_d  = pick_gnt ? addr1 : addr0;
          din_d   = pick_gnt ? wdata1 : wdata0;
          str_d   = sel_we;
          ld_d    = ~sel_we;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        str_d   = 1'b0;
        ld_d    = 1'b0;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        busy_d  = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        str_d   = 1'b0;
        ld_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers; reset favours port 0 on the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      str_q   <= 1'b0;
      ld_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      str_q   <= str_d;
      ld_q    <= ld_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign ram_str  = str_q;
  assign ram_ld   = ld_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign rdata0   = ram_dout;
  assign rdata1   = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a behavioural RAM.
// Directed table, corner sequences and a random run vs a model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_str, ram_ld;
  logic [31:0] ram_dout;
  logic        busy;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .ack0     (ack0),
    .rdata0   (rdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .ack1     (ack1),
    .rdata1   (rdata1),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_str  (ram_str),
    .ram_ld   (ram_ld),
    .ram_dout (ram_dout),
    .busy     (busy)
  );

  // behavioural RAM: registered read, synchronous write, no reset
  logic [31:0] mem [1024];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      ram_dout <= '0;
    end else begin
      if (ram_str) mem[ram_addr] <= ram_din;
      if (ram_ld) ram_dout <= mem[ram_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  logic [31:0] m_mem [1024];
  bit          m_last;
  int          cyc = 0;
  int          free_edge, iss_cyc, ack_cyc;
  bit          e_gnt, e_we;
  logic [9:0]  e_addr;
  logic [31:0] e_din, e_rdata;
  int          grants[$];
  int          acks[$];
  bit          done0, done1;
  int          nxt0, nxt1;

  typedef struct {
    bit          port;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic txn(bit p, bit we, logic [9:0] a, logic [31:0] d,
                     logic [31:0] exp);
    @(posedge clk);
    #1;
    if (p) begin
      req1 = 1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1; we0 = we; addr0 = a; wdata0 = d;
    end
    @(posedge clk);
    @(negedge clk);
    chk("tx_str", ram_str, we);
    chk("tx_ld", ram_ld, !we);
    chk("tx_addr", ram_addr, a);
    chk("tx_busy_iss", busy, 1);
    chk("tx_noack_iss", {ack0, ack1}, 0);
    @(negedge clk);
    chk("tx_ack0", ack0, !p);
    chk("tx_ack1", ack1, p);
    chk("tx_strld_ack", {ram_str, ram_ld}, 0);
    if (!we) chk("tx_rdata", p ? rdata1 : rdata0, exp);
    @(posedge clk);
    #1;
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("tx_idle", {busy, ack0, ack1, ram_str, ram_ld}, 0);
    if (we) m_mem[a] = d;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0;
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    m_last = 1;
    free_edge = 0;
    iss_cyc = -100;
    ack_cyc = -100;
  endtask

  function automatic logic [9:0] rand_addr();
    return ($urandom_range(0, 9) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
  endfunction

  task automatic drive(int mode);
    if (mode == 0) begin
      if (done0) begin done0 = 0; req0 = 0; end
      if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1; we0 = 1'($urandom_range(0, 1));
        addr0 = rand_addr(); wdata0 = $urandom;
      end
      if (done1) begin done1 = 0; req1 = 0; end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1; we1 = 1'($urandom_range(0, 1));
        addr1 = rand_addr(); wdata1 = $urandom;
      end
    end else if (mode == 1) begin
      if (!req0 || done0) begin
        done0 = 0; req0 = 1; we0 = 0; addr0 = 10'(nxt0); nxt0 += 2;
      end
      if (!req1 || done1) begin
        done1 = 0; req1 = 1; we1 = 0; addr1 = 10'(nxt1); nxt1 += 2;
      end
    end else begin
      req0 = 0;
      if (done1) begin done1 = 0; req1 = 0; end
      if (!req1 && nxt1 < 4) begin
        req1 = 1; we1 = 0; addr1 = 10'(nxt1); nxt1++;
      end
    end
  endtask

  task automatic sim(int n, int mode);
    bit ex_iss, ex_ack;
    grants.delete();
    acks.delete();
    done0 = 0;
    done1 = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      if (cyc >= free_edge && (req0 || req1)) begin
        bit p;
        p = (req0 && req1) ? !m_last : req1;
        m_last = p;
        iss_cyc = cyc;
        ack_cyc = cyc + 1;
        free_edge = cyc + 3;
        e_gnt = p;
        e_we = p ? we1 : we0;
        e_addr = p ? addr1 : addr0;
        e_din = p ? wdata1 : wdata0;
        e_rdata = m_mem[e_addr];
        if (e_we) m_mem[e_addr] = e_din;
        grants.push_back(int'(p));
      end
      #1;
      drive(mode);
      @(negedge clk);
      ex_iss = (cyc == iss_cyc);
      ex_ack = (cyc == ack_cyc);
      chk("m_ack0", ack0, ex_ack && !e_gnt);
      chk("m_ack1", ack1, ex_ack && e_gnt);
      chk("m_busy", busy, ex_iss || ex_ack);
      chk("m_str", ram_str, ex_iss && e_we);
      chk("m_ld", ram_ld, ex_iss && !e_we);
      if (ex_iss) chk("m_addr", ram_addr, e_addr);
      if (ex_iss && e_we) chk("m_din", ram_din, e_din);
      if (ex_ack && !e_we) chk("m_rdata", e_gnt ? rdata1 : rdata0, e_rdata);
      if (ack0) begin done0 = 1; acks.push_back(cyc); end
      if (ack1) begin done1 = 1; acks.push_back(cyc); end
    end
  endtask

  initial begin
    bit seen;
    rst = 1; mem_clr = 1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    vecs[0] = '{0, 1, 10'd5,    32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 0, 10'd5,    32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 1, 10'd10,   32'hCAFEF00D, 32'h0};
    vecs[3] = '{1, 0, 10'd10,   32'h0,        32'hCAFEF00D};
    vecs[4] = '{0, 0, 10'd10,   32'h0,        32'hCAFEF00D};
    vecs[5] = '{1, 0, 10'd5,    32'h0,        32'hDEADBEEF};
    vecs[6] = '{0, 1, 10'd1023, 32'hA5A5A5A5, 32'h0};
    vecs[7] = '{1, 0, 10'd1023, 32'h0,        32'hA5A5A5A5};
    vecs[8] = '{0, 0, 10'd0,    32'h0,        32'h0};

    repeat (3) @(posedge clk);
    #1 mem_clr = 0;
    @(negedge clk);
    chk("rst_outs", {ack0, ack1, busy, ram_str, ram_ld}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 9; i++)
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    @(posedge clk);
    #1;
    req1 = 1; we1 = 1; addr1 = 10'd7; wdata1 = 32'h1234;
    @(posedge clk);
    #1;
    rst = 1; req1 = 0;
    @(negedge clk);
    chk("midop_str", ram_str, 1);
    @(posedge clk);
    @(negedge clk);
    chk("midop_outs", {ack0, ack1, busy, ram_str, ram_ld}, 0);
    chk("midop_addr", ram_addr, 0);
    chk("midop_din", ram_din, 0);
    @(posedge clk);
    #1 rst = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack1 || ack0) seen = 1;
    end
    chk("midop_noack", seen, 0);
    m_mem[7] = 32'h1234;
    txn(0, 0, 10'd7, 32'h0, 32'h1234);

    do_reset();
    nxt0 = 1; nxt1 = 2;
    sim(28, 1);
    chk("fair_cnt", grants.size() >= 8, 1);
    chk("fair_acks", acks.size() >= 8, 1);
    for (int i = 0; i < 8; i++)
      if (i < grants.size()) chk("fair_gnt", grants[i], i % 2);
    for (int i = 1; i < 8; i++)
      if (i < acks.size()) chk("fair_gap", acks[i] - acks[i-1], 3);

    do_reset();
    sim(600, 0);

    do_reset();
    nxt1 = 0;
    sim(18, 2);
    chk("b2b_cnt", acks.size(), 4);
    for (int i = 1; i < 4; i++)
      if (i < acks.size()) chk("b2b_gap", acks[i] - acks[i-1], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
